spi_command_master: RTL and testbench
=====================================

SPI_COMMAND_MASTER -- requirements
Module: spi_command_master

Interface
REQ-001 Parameter CLK_DIV, default 2, system clocks per SCLK half-period (legal >= 1).
REQ-002 Parameter LATCH_CYCLES, default 2, width in clocks of the latch_data and control_trigger pulses (legal >= 1).
REQ-003 Ports, one per line:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_data_in  in  32  command word to send.
- cmd_valid  in  1  cmd_data_in is valid.
- cmd_ready  out  1  block will accept a word this cycle.
- trigger_req  in  1  request one control_trigger pulse.
- sclk  out  1  SPI clock to the controller.
- mosi  out  1  SPI data to the controller.
- ss_n  out  1  SPI select, active low.
- miso  in  1  SPI data from the controller.
- latch_data  out  1  pulse: the controller latches the received word.
- control_trigger  out  1  pulse: the controller starts its cycle.
- rx_data  out  32  word shifted in on miso.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The SPI link SHALL use mode 0 (CPOL=0, CPHA=0), MSB first, 32 bits per frame, with one ss_n assertion per frame.
REQ-005 The FSM SHALL have the states IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP, LATCH and TRIG, and every timed state SHALL last CLK_DIV clocks, except LATCH and TRIG, which SHALL last LATCH_CYCLES clocks.
REQ-006 cmd_ready SHALL equal (state==IDLE && !reset), and a word SHALL be accepted when cmd_valid && cmd_ready, capturing cmd_data_in into the shift register and entering SETUP.
REQ-007 In SETUP, ss_n SHALL be 0, sclk SHALL be 0 and mosi SHALL be bit 31.
REQ-008 On entry to SCLK_HI, sclk SHALL be 1 and miso SHALL be sampled into rx_shift[0] after a left shift.
REQ-009 On entry to SCLK_LO, sclk SHALL be 0 and mosi SHALL advance to the next bit.
REQ-010 After the 32nd SCLK_HI/SCLK_LO pair the FSM SHALL go to HOLD; a 5-bit bit counter SHALL count down from 31 and SHALL NOT wrap within a frame.
REQ-011 In HOLD, ss_n SHALL stay 0 and sclk 0.
REQ-012 In GAP, ss_n SHALL be 1; rx_data SHALL load rx_shift and rx_valid SHALL pulse for 1 clock on GAP entry.
REQ-013 In LATCH, latch_data SHALL be 1, after which the FSM SHALL return to IDLE.
REQ-014 Frame latency from the accept cycle to the return to IDLE SHALL be CLK_DIV*67 + LATCH_CYCLES clocks (136 at the defaults).
REQ-015 A trigger_pending flag SHALL be set by trigger_req in any cycle and cleared on TRIG entry; multiple requests before service SHALL collapse into one.
REQ-016 In IDLE, an accepted command SHALL take priority over trigger_pending; otherwise a set trigger_pending SHALL enter TRIG (control_trigger=1, ss_n=1), then IDLE.
REQ-017 control_trigger and latch_data SHALL never be high simultaneously, and neither SHALL be high while ss_n=0.
REQ-018 All SPI outputs and pulses SHALL be registered, with no combinational path from miso to any output.

Reset
REQ-019 Reset SHALL force state=IDLE, sclk=0, ss_n=1, mosi=0, latch_data=0, control_trigger=0, rx_valid=0, rx_data=0, trigger_pending=0, busy=0 and the counters to 0.
REQ-020 Reset asserted mid-frame SHALL abort on the next clock edge, with ss_n=1 and sclk=0 and no latch_data pulse; the partial word SHALL be discarded.

Structure
REQ-021 The state encoding, the frame width (32) and the default CLK_DIV/LATCH_CYCLES constants SHALL live in the shared package micro_motor_pkg.
REQ-022 The half-period tick generator SHALL be the sub-module spi_tick_gen (a counter 0..CLK_DIV-1, restarted on each state entry, emitting a tick on the terminal count).

Verification
REQ-023 Defaults, send 0xA5C3_0F81 with miso=0 -> the bench's mode-0 slave receives 0xA5C3_0F81, rx_data=0, rx_valid pulses once, latch_data is high for 2 clocks after ss_n rises, and cmd_ready returns 136 clocks after accept.
REQ-024 miso driven from a slave loaded with 0x1234_5678 -> rx_data=0x1234_5678 at the rx_valid pulse.
REQ-025 cmd_valid and trigger_req asserted together in IDLE -> the frame is sent first, then exactly one 2-clock control_trigger pulse with ss_n=1.
REQ-026 trigger_req pulsed 3 times mid-frame -> exactly one control_trigger pulse after the frame.
REQ-027 Reset asserted at bit 17 -> the next clock shows ss_n=1, sclk=0 and latch_data=0; a following 0x0000_0001 frame is received intact.
REQ-028 CLK_DIV=1 with back-to-back cmd_valid of 0xFFFF_FFFF then 0x0000_0000 -> both frames are correct, ss_n is high for at least 1 clock between frames, and sclk has exactly 32 rising edges per frame.

Source files
------------

// File: rtl/micro_motor_pkg.sv
// Shared definitions for the SPI command master: FSM encoding, frame width
// and default timing constants.
package micro_motor_pkg;

    localparam int FRAME_BITS           = 32;
    localparam int DEFAULT_CLK_DIV      = 2;
    localparam int DEFAULT_LATCH_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD,
        GAP,
        LATCH,
        TRIG
    } spi_state_t;

    // States during which the controller is selected (ss_n low).
    function automatic logic select_active(input spi_state_t s);
        return (s == SETUP) || (s == SCLK_HI) || (s == SCLK_LO) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: counts 0..N-1 from each state entry and ticks on
// the terminal count, N being CLK_DIV or LATCH_CYCLES for the pulse states.
module spi_tick_gen
    import micro_motor_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic long_period,
    output logic tick
);

    localparam int MAX_PERIOD = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int CW         = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == (long_period ? LATCH_LAST : DIV_LAST));

    always_ff @(posedge clock) begin
        if (reset || restart || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/spi_command_master.sv
// Mode-0 SPI master that sends 32-bit command words to a motor controller,
// then pulses latch_data; also issues stand-alone control_trigger pulses.
module spi_command_master
    import micro_motor_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cmd_data_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        trigger_req,
    output logic        sclk,
    output logic        mosi,
    output logic        ss_n,
    input  logic        miso,
    output logic        latch_data,
    output logic        control_trigger,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    spi_state_t            state;
    spi_state_t            next_state;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [4:0]            bit_cnt;
    logic                  trigger_pending;
    logic                  tick;
    logic                  accept;
    logic                  entering;
    logic                  long_period;

    assign cmd_ready   = (state == IDLE) && !reset;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state != IDLE);
    assign entering    = (next_state != state);
    assign long_period = (state == LATCH) || (state == TRIG);

    spi_tick_gen #(
        .CLK_DIV      (CLK_DIV),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) u_tick_gen (
        .clock       (clock),
        .reset       (reset),
        .restart     (entering),
        .long_period (long_period),
        .tick        (tick)
    );

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SETUP;
                end else if (trigger_pending) begin
                    next_state = TRIG;
                end
            end
            SETUP:   if (tick) next_state = SCLK_HI;
            SCLK_HI: if (tick) next_state = SCLK_LO;
            SCLK_LO: if (tick) next_state = (bit_cnt == 5'd0) ? HOLD : SCLK_HI;
            HOLD:    if (tick) next_state = GAP;
            GAP:     if (tick) next_state = LATCH;
            LATCH:   if (tick) next_state = IDLE;
            TRIG:    if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state into flops so every pin is registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            sclk            <= 1'b0;
            mosi            <= 1'b0;
            ss_n            <= 1'b1;
            latch_data      <= 1'b0;
            control_trigger <= 1'b0;
            rx_valid        <= 1'b0;
            rx_data         <= '0;
            rx_shift        <= '0;
            tx_shift        <= '0;
            bit_cnt         <= '0;
            trigger_pending <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state           <= next_state;
            sclk            <= (next_state == SCLK_HI);
            ss_n            <= !select_active(next_state);
            latch_data      <= (next_state == LATCH);
            control_trigger <= (next_state == TRIG);
            rx_valid        <= (next_state == GAP) && (state != GAP);
            trigger_pending <= trigger_req ||
                               (trigger_pending && !((next_state == TRIG) && (state != TRIG)));

            if (accept) begin
                tx_shift <= cmd_data_in;
                mosi     <= cmd_data_in[FRAME_BITS-1];
                bit_cnt  <= LAST_BIT;
                rx_shift <= '0;
            end

            if ((state == SCLK_HI) && (next_state == SCLK_LO)) begin
                tx_shift <= tx_shift << 1;
                mosi     <= tx_shift[FRAME_BITS-2];
            end

            if ((state == SCLK_LO) && (next_state == SCLK_HI)) begin
                bit_cnt <= bit_cnt - 5'd1;
            end

            if ((next_state == SCLK_HI) && (state != SCLK_HI)) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], miso};
            end

            if ((next_state == GAP) && (state != GAP)) begin
                rx_data <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_command_master.sv
// Bench for spi_command_master: a frame-offset timing model checked every cycle,
// mode-0 slaves on both instances, and directed scenarios with literal checks.
module tb_spi_command_master;

    localparam int CD0 = 2;
    localparam int CD1 = 1;
    localparam int LC  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: default timing
    logic        rst0 = 1'b1, valid0 = 1'b0, treq0 = 1'b0, miso0 = 1'b0;
    logic [31:0] data0 = '0, load0 = '0;
    logic        ready0, sclk0, mosi0, ss_n0, latch0, trig0, rxv0, busy0;
    logic [31:0] rxd0;

    // Instance 1: CLK_DIV = 1
    logic        rst1 = 1'b1, valid1 = 1'b0, treq1 = 1'b0, miso1 = 1'b0;
    logic [31:0] data1 = '0, load1 = '0;
    logic        ready1, sclk1, mosi1, ss_n1, latch1, trig1, rxv1, busy1;
    logic [31:0] rxd1;

    spi_command_master #(.CLK_DIV(CD0), .LATCH_CYCLES(LC)) u_dut0 (
        .clock(clock), .reset(rst0), .cmd_data_in(data0), .cmd_valid(valid0),
        .cmd_ready(ready0), .trigger_req(treq0), .sclk(sclk0), .mosi(mosi0),
        .ss_n(ss_n0), .miso(miso0), .latch_data(latch0), .control_trigger(trig0),
        .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0)
    );

    spi_command_master #(.CLK_DIV(CD1), .LATCH_CYCLES(LC)) u_dut1 (
        .clock(clock), .reset(rst1), .cmd_data_in(data1), .cmd_valid(valid1),
        .cmd_ready(ready1), .trigger_req(treq1), .sclk(sclk1), .mosi(mosi1),
        .ss_n(ss_n1), .miso(miso1), .latch_data(latch1), .control_trigger(trig1),
        .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1)
    );

    // Mode-0 slaves: drive miso from ss_n fall and after each sclk fall, sample mosi on sclk rise.
    logic [31:0] s0_tx = '0, s0_rx = '0, s1_tx = '0, s1_rx = '0;
    int          s0_edges = 0, s1_edges = 0;
    logic        s0_ss_q = 1'b1, s0_sclk_q = 1'b0, s1_ss_q = 1'b1, s1_sclk_q = 1'b0;
    logic [31:0] s0_words[$], s1_words[$];
    int          s0_edge_log[$], s1_edge_log[$];

    always @(ss_n0 or sclk0) begin
        if (s0_ss_q && ss_n0 === 1'b0) begin
            s0_tx = load0; s0_rx = '0; s0_edges = 0;
        end else if (!s0_ss_q && ss_n0 === 1'b1 && s0_edges > 0) begin
            s0_words.push_back(s0_rx); s0_edge_log.push_back(s0_edges);
        end
        if (ss_n0 === 1'b0) begin
            if (!s0_sclk_q && sclk0 === 1'b1) begin
                s0_rx = {s0_rx[30:0], mosi0}; s0_edges++;
            end else if (s0_sclk_q && sclk0 === 1'b0) begin
                s0_tx = s0_tx << 1;
            end
        end
        miso0 = s0_tx[31];
        s0_ss_q = (ss_n0 !== 1'b0); s0_sclk_q = (sclk0 === 1'b1);
    end

    always @(ss_n1 or sclk1) begin
        if (s1_ss_q && ss_n1 === 1'b0) begin
            s1_tx = load1; s1_rx = '0; s1_edges = 0;
        end else if (!s1_ss_q && ss_n1 === 1'b1 && s1_edges > 0) begin
            s1_words.push_back(s1_rx); s1_edge_log.push_back(s1_edges);
        end
        if (ss_n1 === 1'b0) begin
            if (!s1_sclk_q && sclk1 === 1'b1) begin
                s1_rx = {s1_rx[30:0], mosi1}; s1_edges++;
            end else if (s1_sclk_q && sclk1 === 1'b0) begin
                s1_tx = s1_tx << 1;
            end
        end
        miso1 = s1_tx[31];
        s1_ss_q = (ss_n1 !== 1'b0); s1_sclk_q = (sclk1 === 1'b1);
    end

    // Behavioural model: an activity plus the clock offset p into it.
    typedef enum int {M_IDLE, M_FRAME, M_TRIG} mkind_t;
    typedef struct {
        mkind_t      kind;
        int          p;
        logic [31:0] word;
        logic        pending;
        logic [31:0] rx_exp;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t model_step(input mstate_t m, input int cd, input logic rst,
                                           input logic valid, input logic [31:0] data,
                                           input logic treq, input logic [31:0] slave_word);
        mstate_t n;
        logic    start_trig;
        n = m;
        start_trig = 1'b0;
        if (rst) begin
            n.kind = M_IDLE; n.p = 0; n.pending = 1'b0; n.rx_exp = '0;
            return n;
        end
        case (m.kind)
            M_IDLE: begin
                if (valid) begin
                    n.kind = M_FRAME; n.p = 0; n.word = data;
                end else if (m.pending) begin
                    n.kind = M_TRIG; n.p = 0; start_trig = 1'b1;
                end
            end
            M_FRAME: begin
                n.p = m.p + 1;
                if (n.p == 66 * cd) n.rx_exp = slave_word;
                if (n.p == 67 * cd + LC) begin n.kind = M_IDLE; n.p = 0; end
            end
            default: begin
                n.p = m.p + 1;
                if (n.p == LC) begin n.kind = M_IDLE; n.p = 0; end
            end
        endcase
        n.pending = treq || (m.pending && !start_trig);
        return n;
    endfunction

    // Packed as {sclk, mosi, ss_n, latch_data, control_trigger, rx_valid, busy, cmd_ready}.
    function automatic logic [7:0] exp_out(input mstate_t m, input int cd, input logic rst);
        logic sclk_e, mosi_e, ss_e, lat_e, trg_e, rv_e, busy_e, rdy_e;
        int   s, k;
        sclk_e = 1'b0; mosi_e = 1'b0; ss_e = 1'b1; lat_e = 1'b0;
        trg_e = 1'b0; rv_e = 1'b0; busy_e = 1'b0; rdy_e = 1'b0;
        case (m.kind)
            M_IDLE: rdy_e = !rst;
            M_FRAME: begin
                busy_e = 1'b1;
                s      = m.p / cd;
                ss_e   = (s > 65);
                sclk_e = (s >= 1) && (s <= 64) && ((s % 2) == 1);
                k      = s / 2;
                if (k < 32) mosi_e = m.word[31 - k];
                rv_e   = (m.p == 66 * cd);
                lat_e  = (m.p >= 67 * cd);
            end
            default: begin busy_e = 1'b1; trg_e = 1'b1; end
        endcase
        return {sclk_e, mosi_e, ss_e, lat_e, trg_e, rv_e, busy_e, rdy_e};
    endfunction

    always @(posedge clock) begin
        m0 = model_step(m0, CD0, rst0, valid0, data0, treq0, load0);
        m1 = model_step(m1, CD1, rst1, valid1, data1, treq1, load1);
    end

    int   n_checks = 0, n_fail = 0;
    int   n_rxv0 = 0, n_latch0 = 0, n_trigc0 = 0, n_trigp0 = 0;
    logic trig0_q = 1'b0;
    int   hi_run1 = 0, last_gap1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare both instances against the model mid-cycle, then move
    // to just after the next rising edge where stimulus is applied.
    task automatic step();
        @(negedge clock);
        check("outputs0", {24'd0, sclk0, mosi0, ss_n0, latch0, trig0, rxv0, busy0, ready0},
              {24'd0, exp_out(m0, CD0, rst0)});
        check("rx_data0", rxd0, m0.rx_exp);
        check("outputs1", {24'd0, sclk1, mosi1, ss_n1, latch1, trig1, rxv1, busy1, ready1},
              {24'd0, exp_out(m1, CD1, rst1)});
        check("rx_data1", rxd1, m1.rx_exp);
        if (rxv0) n_rxv0++;
        if (latch0) n_latch0++;
        if (trig0) n_trigc0++;
        if (trig0 && !trig0_q) n_trigp0++;
        trig0_q = trig0;
        if (ss_n1) begin
            hi_run1++;
        end else begin
            if (hi_run1 > 0) last_gap1 = hi_run1;
            hi_run1 = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic accept0(input logic [31:0] w, input logic with_trig);
        int g;
        g = 0;
        while (!ready0 && g < 500) begin step(); g++; end
        check("accept0_wait", 32'(g < 500), 32'd1);
        data0 = w; valid0 = 1'b1; treq0 = with_trig;
        step();
        valid0 = 1'b0; treq0 = 1'b0;
    endtask

    task automatic wait_ready0(output int lat);
        lat = 0;
        do begin step(); lat++; end while (!ready0 && lat < 2000);
    endtask

    initial begin
        int lat, rxv_b, lat_b, tc_b, tp_b, g, nw1;

        step();
        check("reset_ready", ready0, 1'b0);
        check("reset_ss_n", ss_n0, 1'b1);
        check("reset_busy", busy0, 1'b0);
        step();
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) step();

        // Basic frame with miso held low
        load0 = 32'h0000_0000;
        rxv_b = n_rxv0; lat_b = n_latch0;
        accept0(32'hA5C3_0F81, 1'b0);
        wait_ready0(lat);
        check("frame_latency", lat, 32'd136);
        check("slave_rx_A5C3", s0_words[s0_words.size() - 1], 32'hA5C3_0F81);
        check("slave_edges_A5C3", s0_edge_log[s0_edge_log.size() - 1], 32'd32);
        check("rx_data_zero", rxd0, 32'h0);
        check("rx_valid_once", n_rxv0 - rxv_b, 32'd1);
        check("latch_width", n_latch0 - lat_b, 32'd2);

        // Slave returns a known word on miso
        load0 = 32'h1234_5678;
        accept0(32'h0F0F_C33C, 1'b0);
        wait_ready0(lat);
        check("rx_data_1234", rxd0, 32'h1234_5678);
        check("slave_rx_0F0F", s0_words[s0_words.size() - 1], 32'h0F0F_C33C);

        // Command and trigger together: frame first, one trigger afterwards
        tc_b = n_trigc0; tp_b = n_trigp0;
        accept0(32'h3C3C_5A5A, 1'b1);
        wait_ready0(lat);
        check("trig_after_frame_none_yet", n_trigp0 - tp_b, 32'd0);
        repeat (6) step();
        check("trig_pulses_combo", n_trigp0 - tp_b, 32'd1);
        check("trig_width_combo", n_trigc0 - tc_b, 32'd2);
        check("slave_rx_3C3C", s0_words[s0_words.size() - 1], 32'h3C3C_5A5A);

        // Three trigger requests during a frame collapse into one pulse
        tp_b = n_trigp0; tc_b = n_trigc0;
        accept0(32'h0000_FFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (15) step();
            treq0 = 1'b1; step(); treq0 = 1'b0;
        end
        wait_ready0(lat);
        repeat (6) step();
        check("trig_pulses_collapsed", n_trigp0 - tp_b, 32'd1);
        check("trig_width_collapsed", n_trigc0 - tc_b, 32'd2);

        // Reset at bit 17 (bit 17 high phase starts 70 clocks after accept)
        load0 = 32'hC0DE_0042;
        lat_b = n_latch0;
        accept0(32'hFFFF_0000, 1'b0);
        repeat (70) step();
        check("bit17_sclk_high", sclk0, 1'b1);
        rst0 = 1'b1;
        step();
        check("abort_ss_n", ss_n0, 1'b1);
        check("abort_sclk", sclk0, 1'b0);
        check("abort_latch", latch0, 1'b0);
        check("abort_rx_data", rxd0, 32'h0);
        rst0 = 1'b0;
        repeat (3) step();
        check("abort_no_latch", n_latch0 - lat_b, 32'd0);
        accept0(32'h0000_0001, 1'b0);
        wait_ready0(lat);
        check("after_abort_slave_rx", s0_words[s0_words.size() - 1], 32'h0000_0001);
        check("after_abort_edges", s0_edge_log[s0_edge_log.size() - 1], 32'd32);
        check("after_abort_rx_data", rxd0, 32'hC0DE_0042);

        // CLK_DIV=1 instance: back-to-back frames with cmd_valid held
        load1 = 32'h5555_AAAA;
        nw1 = s1_words.size();
        data1 = 32'hFFFF_FFFF; valid1 = 1'b1;
        step();
        data1 = 32'h0000_0000;
        g = 0;
        while (!ready1 && g < 500) begin step(); g++; end
        check("fast_first_done", 32'(g < 500), 32'd1);
        step();
        valid1 = 1'b0;
        g = 0;
        while (!ready1 && g < 500) begin step(); g++; end
        check("fast_second_done", 32'(g < 500), 32'd1);
        check("fast_frame_count", s1_words.size() - nw1, 32'd2);
        if (s1_words.size() - nw1 == 2) begin
            check("fast_rx_ffff", s1_words[nw1], 32'hFFFF_FFFF);
            check("fast_rx_0000", s1_words[nw1 + 1], 32'h0000_0000);
            check("fast_edges_1", s1_edge_log[nw1], 32'd32);
            check("fast_edges_2", s1_edge_log[nw1 + 1], 32'd32);
        end
        check("fast_gap_min", 32'(last_gap1 >= 1), 32'd1);
        check("fast_rx_data", rxd1, 32'h5555_AAAA);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
